// File: rtl/timer_counter.sv
`default_nettype none
// ============================================================================
// Module      : timer_counter
// Description : 64-bit free-running timer with a power-of-two prescaler,
//               half-word loads, synchronous clear, sticky compare-match
//               interrupt and an optional debug-halt freeze.
//               Optional feature macro: TIMER_HALT_SUPPORT_EN
//                 defined   -> halt_req is registered into halt_ack_status and
//                              freezes the counter and prescaler while set.
//                 undefined -> halt_req is ignored, halt_ack_status reads 0.
// Revision    : 1.0 - initial release
// ============================================================================
module timer_counter (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        timer_en,
   input  logic        div_en,
   input  logic [3:0]  div_val,
   input  logic        halt_req,
   input  logic        counter_clear,
   input  logic [1:0]  counter_write_sel,
   input  logic [31:0] counter_write_data,
   input  logic [63:0] compare_val,
   input  logic        interrupt_en,
   input  logic        interrupt_clear,
   output logic [63:0] cnt_val,
   output logic        halt_ack_status,
   output logic        interrupt_status,
   output logic        tim_int
);

   // Largest supported prescaler exponent; larger requests saturate here.
   localparam logic [3:0] C_DIV_MAX = 4'd8;

   logic [63:0] r_cnt;
   logic [7:0]  r_div_cnt;
   logic        r_int_status;

   logic [3:0]  w_div_eff;
   logic [7:0]  w_div_term;
   logic        w_div_active;
   logic        w_halted;
   logic        w_tick;
   logic        w_match;

   // ------------------------------------------------------------------------
   // Debug halt: acknowledge lags the request by one cycle, and the
   // acknowledge itself (not the raw request) is what freezes counting.
   // ------------------------------------------------------------------------
`ifdef TIMER_HALT_SUPPORT_EN
   logic r_halt_ack;

   // Register the halt request to form the acknowledge.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_halt_ack <= 1'b0;
      end else begin
         r_halt_ack <= halt_req;
      end
   end

   assign w_halted        = r_halt_ack;
   assign halt_ack_status = r_halt_ack;
`else
   logic w_unused_halt_req;

   assign w_unused_halt_req = halt_req;
   assign w_halted          = 1'b0;
   assign halt_ack_status   = 1'b0;
`endif

   // ------------------------------------------------------------------------
   // Prescaler
   // ------------------------------------------------------------------------

   // Saturate the exponent and derive the terminal count 2^n - 1.
   always_comb begin
      w_div_eff  = (div_val > C_DIV_MAX) ? C_DIV_MAX : div_val;
      w_div_term = 8'd0;
      case (w_div_eff)
         4'd0:    w_div_term = 8'd0;
         4'd1:    w_div_term = 8'd1;
         4'd2:    w_div_term = 8'd3;
         4'd3:    w_div_term = 8'd7;
         4'd4:    w_div_term = 8'd15;
         4'd5:    w_div_term = 8'd31;
         4'd6:    w_div_term = 8'd63;
         4'd7:    w_div_term = 8'd127;
         default: w_div_term = 8'd255;
      endcase
   end

   // A divide of 2^0 behaves exactly like the prescaler being bypassed.
   assign w_div_active = div_en && (w_div_eff != 4'd0);

   // Counter advances on every enabled cycle when bypassed, otherwise
   // only when the prescaler reaches its terminal count.
   assign w_tick = timer_en && !w_halted &&
                   (!w_div_active || (r_div_cnt == w_div_term));

   // Prescaler count: cleared when idle, frozen while halted, wraps on tick.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_div_cnt <= 8'd0;
      end else if (!timer_en || !div_en) begin
         r_div_cnt <= 8'd0;
      end else if (w_halted) begin
         r_div_cnt <= r_div_cnt;
      end else if (!w_div_active) begin
         r_div_cnt <= 8'd0;
      end else if (w_tick) begin
         r_div_cnt <= 8'd0;
      end else begin
         r_div_cnt <= r_div_cnt + 8'd1;
      end
   end

   // ------------------------------------------------------------------------
   // Main 64-bit counter
   // ------------------------------------------------------------------------

   // Clear beats load beats increment; a load suppresses the increment so
   // the unselected half keeps its exact previous value.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_cnt <= 64'd0;
      end else if (counter_clear) begin
         r_cnt <= 64'd0;
      end else if (counter_write_sel != 2'b00) begin
         if (counter_write_sel[0]) begin
            r_cnt[31:0] <= counter_write_data;
         end
         if (counter_write_sel[1]) begin
            r_cnt[63:32] <= counter_write_data;
         end
      end else if (w_tick) begin
         r_cnt <= r_cnt + 64'd1;
      end
   end

   assign cnt_val = r_cnt;

   // ------------------------------------------------------------------------
   // Compare / interrupt
   // ------------------------------------------------------------------------

   // Compare against the registered count regardless of timer_en, so a
   // load that lands on the threshold also raises the flag.
   assign w_match = (r_cnt == compare_val);

   // Sticky status: a match in the same cycle wins over a clear request.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_int_status <= 1'b0;
      end else if (w_match) begin
         r_int_status <= 1'b1;
      end else if (interrupt_clear) begin
         r_int_status <= 1'b0;
      end
   end

   assign interrupt_status = r_int_status;
   assign tim_int          = r_int_status && interrupt_en;

endmodule
`default_nettype wire

// File: tb/tb_timer_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_timer_counter
// Description : Directed self-checking bench for timer_counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_counter;

   logic        sys_clk;
   logic        sys_rst_n;
   logic        timer_en;
   logic        div_en;
   logic [3:0]  div_val;
   logic        halt_req;
   logic        counter_clear;
   logic [1:0]  counter_write_sel;
   logic [31:0] counter_write_data;
   logic [63:0] compare_val;
   logic        interrupt_en;
   logic        interrupt_clear;
   logic [63:0] cnt_val;
   logic        halt_ack_status;
   logic        interrupt_status;
   logic        tim_int;

   int n_checks = 0;
   int n_fails  = 0;

   localparam logic [63:0] C_FAR_CMP = 64'h1234_0000_0000_0000;

   timer_counter u_dut (
      .sys_clk            (sys_clk),
      .sys_rst_n          (sys_rst_n),
      .timer_en           (timer_en),
      .div_en             (div_en),
      .div_val            (div_val),
      .halt_req           (halt_req),
      .counter_clear      (counter_clear),
      .counter_write_sel  (counter_write_sel),
      .counter_write_data (counter_write_data),
      .compare_val        (compare_val),
      .interrupt_en       (interrupt_en),
      .interrupt_clear    (interrupt_clear),
      .cnt_val            (cnt_val),
      .halt_ack_status    (halt_ack_status),
      .interrupt_status   (interrupt_status),
      .tim_int            (tim_int)
   );

   // 10 ns clock
   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   // Compare one observed value against its expected value.
   task automatic check_val(input string tag, input logic [63:0] obs,
                            input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance n rising edges and settle 1 ns past the last one.
   task automatic step(input int n);
      repeat (n) @(posedge sys_clk);
      #1;
   endtask

   initial begin
      sys_rst_n          = 1'b0;
      timer_en           = 1'b0;
      div_en             = 1'b0;
      div_val            = 4'd0;
      halt_req           = 1'b0;
      counter_clear      = 1'b0;
      counter_write_sel  = 2'b00;
      counter_write_data = 32'd0;
      compare_val        = C_FAR_CMP;
      interrupt_en       = 1'b0;
      interrupt_clear    = 1'b0;

      // Reset state
      step(3);
      check_val("rst_cnt", cnt_val, 64'd0);
      check_val("rst_int_status", {63'd0, interrupt_status}, 64'd0);
      check_val("rst_tim_int", {63'd0, tim_int}, 64'd0);
      check_val("rst_halt_ack", {63'd0, halt_ack_status}, 64'd0);
      sys_rst_n = 1'b1;

      // Undivided counting: 10 cycles -> 10
      timer_en = 1'b1;
      step(10);
      check_val("nodiv_10", cnt_val, 64'd10);
      timer_en = 1'b0;
      step(2);
      check_val("hold_disabled", cnt_val, 64'd10);

      // Synchronous clear
      counter_clear = 1'b1;
      step(1);
      counter_clear = 1'b0;
      check_val("clear", cnt_val, 64'd0);

      // Divide by 4: one tick on every 4th cycle, 16 cycles -> 4
      div_en   = 1'b1;
      div_val  = 4'd2;
      timer_en = 1'b1;
      step(3);
      check_val("div4_before_tick", cnt_val, 64'd0);
      step(1);
      check_val("div4_first_tick", cnt_val, 64'd1);
      step(12);
      check_val("div4_16cyc", cnt_val, 64'd4);
      timer_en = 1'b0;
      counter_clear = 1'b1;
      step(1);
      counter_clear = 1'b0;

      // div_val above 8 saturates to divide-by-256
      div_val  = 4'd12;
      timer_en = 1'b1;
      step(255);
      check_val("div_sat_255", cnt_val, 64'd0);
      step(1);
      check_val("div_sat_256", cnt_val, 64'd1);
      timer_en = 1'b0;
      div_en   = 1'b0;
      div_val  = 4'd0;

      // Half loads while disabled, then 64-bit wrap
      counter_write_sel  = 2'b10;
      counter_write_data = 32'hFFFF_FFFF;
      step(1);
      counter_write_sel  = 2'b01;
      counter_write_data = 32'hFFFF_FFFE;
      step(1);
      counter_write_sel  = 2'b00;
      check_val("load_halves", cnt_val, 64'hFFFF_FFFF_FFFF_FFFE);
      timer_en = 1'b1;
      step(1);
      check_val("count_to_max", cnt_val, 64'hFFFF_FFFF_FFFF_FFFF);
      step(1);
      check_val("wrap_to_zero", cnt_val, 64'd0);

      // Load while counting: no increment on the load cycle
      counter_write_sel  = 2'b01;
      counter_write_data = 32'h0000_0100;
      step(1);
      counter_write_sel  = 2'b00;
      check_val("load_lo_no_inc", cnt_val, 64'h100);
      step(1);
      check_val("inc_after_load", cnt_val, 64'h101);
      timer_en = 1'b0;

      // Both halves loaded from the same word
      counter_write_sel  = 2'b11;
      counter_write_data = 32'hA5A5_0001;
      step(1);
      counter_write_sel  = 2'b00;
      check_val("load_both", cnt_val, 64'hA5A5_0001_A5A5_0001);

      // Clear beats a simultaneous load
      counter_clear      = 1'b1;
      counter_write_sel  = 2'b01;
      counter_write_data = 32'h55;
      step(1);
      counter_clear      = 1'b0;
      counter_write_sel  = 2'b00;
      check_val("clear_over_load", cnt_val, 64'd0);

      // Compare match at 5
      compare_val = 64'd5;
      timer_en    = 1'b1;
      step(5);
      timer_en    = 1'b0;
      check_val("cmp_cnt5", cnt_val, 64'd5);
      check_val("cmp_not_yet", {63'd0, interrupt_status}, 64'd0);
      step(1);
      check_val("cmp_set", {63'd0, interrupt_status}, 64'd1);
      check_val("tim_int_masked", {63'd0, tim_int}, 64'd0);
      interrupt_en = 1'b1;
      #1;
      check_val("tim_int_unmasked", {63'd0, tim_int}, 64'd1);
      interrupt_clear = 1'b1;
      step(1);
      interrupt_clear = 1'b0;
      check_val("set_beats_clear", {63'd0, interrupt_status}, 64'd1);
      counter_write_sel  = 2'b01;
      counter_write_data = 32'd100;
      step(1);
      counter_write_sel  = 2'b00;
      check_val("sticky", {63'd0, interrupt_status}, 64'd1);
      interrupt_clear = 1'b1;
      step(1);
      interrupt_clear = 1'b0;
      check_val("int_cleared", {63'd0, interrupt_status}, 64'd0);
      check_val("tim_int_cleared", {63'd0, tim_int}, 64'd0);

      // Load equal to compare value sets the flag with timer disabled
      counter_write_sel  = 2'b01;
      counter_write_data = 32'd5;
      step(1);
      counter_write_sel  = 2'b00;
      check_val("load_match_pre", {63'd0, interrupt_status}, 64'd0);
      step(1);
      check_val("load_match_set", {63'd0, interrupt_status}, 64'd1);
      counter_clear = 1'b1;
      step(1);
      counter_clear   = 1'b0;
      interrupt_clear = 1'b1;
      step(1);
      interrupt_clear = 1'b0;
      check_val("load_match_clr", {63'd0, interrupt_status}, 64'd0);
      compare_val  = C_FAR_CMP;
      interrupt_en = 1'b0;

      // Halt mid-prescale with divide-by-8, counter at 7
      counter_write_sel  = 2'b01;
      counter_write_data = 32'd7;
      step(1);
      counter_write_sel  = 2'b00;
      div_en   = 1'b1;
      div_val  = 4'd3;
      timer_en = 1'b1;
      step(3);
      halt_req = 1'b1;
      step(1);
`ifdef TIMER_HALT_SUPPORT_EN
      check_val("halt_ack_set", {63'd0, halt_ack_status}, 64'd1);
      check_val("halt_cnt7", cnt_val, 64'd7);
      step(10);
      check_val("halt_frozen", cnt_val, 64'd7);
      halt_req = 1'b0;
      step(1);
      check_val("halt_ack_clr", {63'd0, halt_ack_status}, 64'd0);
      step(3);
      check_val("resume_pre_tick", cnt_val, 64'd7);
      step(1);
      check_val("resume_tick", cnt_val, 64'd8);
`else
      check_val("halt_ack_tied0", {63'd0, halt_ack_status}, 64'd0);
      step(10);
      check_val("no_halt_freeze", cnt_val, 64'd8);
      halt_req = 1'b0;
      step(1);
      check_val("halt_ack_still0", {63'd0, halt_ack_status}, 64'd0);
      step(4);
      check_val("no_halt_tick2", cnt_val, 64'd9);
`endif
      timer_en = 1'b0;

      // Asynchronous reset mid-prescale discards the partial count
      counter_write_sel  = 2'b01;
      counter_write_data = 32'h77;
      step(1);
      counter_write_sel  = 2'b00;
      div_val  = 4'd2;
      timer_en = 1'b1;
      step(2);
      sys_rst_n = 1'b0;
      #1;
      check_val("async_rst_cnt", cnt_val, 64'd0);
      #2;
      sys_rst_n = 1'b1;
      step(3);
      check_val("post_rst_pre_tick", cnt_val, 64'd0);
      step(1);
      check_val("post_rst_tick", cnt_val, 64'd1);
      timer_en = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/timer_counter.md
TIMER_COUNTER -- requirements
Module: timer_counter

Interface
REQ-001 sys_clk  input  1  block clock; all state updates on rising edge.
REQ-002 sys_rst_n  input  1  asynchronous, active-low reset.
REQ-003 timer_en  input  1  count enable from control register.
REQ-004 div_en  input  1  prescaler enable.
REQ-005 div_val  input  4  prescaler exponent; tick period 2^div_val; legal range 0..8.
REQ-006 halt_req  input  1  debug halt request.
REQ-007 counter_clear  input  1  one-cycle pulse; zero the counter.
REQ-008 counter_write_sel  input  2  bit0 loads cnt[31:0], bit1 loads cnt[63:32].
REQ-009 counter_write_data  input  32  byte-merged load data.
REQ-010 compare_val  input  64  compare threshold.
REQ-011 interrupt_en  input  1  interrupt output mask.
REQ-012 interrupt_clear  input  1  one-cycle pulse; clear interrupt status.
REQ-013 cnt_val  output  64  current counter value, registered.
REQ-014 halt_ack_status  output  1  halt acknowledged, registered.
REQ-015 interrupt_status  output  1  sticky compare-match flag, registered.
REQ-016 tim_int  output  1  interrupt line = interrupt_status AND interrupt_en, combinational.

Function
REQ-017 Prescaler: 8-bit div_cnt; tick when timer_en=1, not halted, and either div_en=0, div_val=0, or div_cnt == 2^div_val-1.
REQ-018 div_cnt increments each cycle timer_en=1, div_en=1, div_val!=0, not halted; wraps to 0 on the tick cycle.
REQ-019 div_cnt forced to 0 whenever timer_en=0 or div_en=0; div_cnt holds its value while halted.
REQ-020 div_val>8 is treated as 8.
REQ-021 Counter update priority per cycle: counter_clear > counter_write_sel load > tick increment > hold.
REQ-022 Load replaces only the selected half in the following cycle; both bits set loads both halves with counter_write_data; the unselected half holds (no increment that cycle).
REQ-023 Increment is +1 modulo 2^64; 64'hFFFF_FFFF_FFFF_FFFF wraps to 0 without any flag.
REQ-024 Loads and clear are accepted while timer_en=0 and while halted.
REQ-025 halt_ack_status = halt_req delayed one cycle; counting and div_cnt freeze from the cycle halt_ack_status=1 until it falls.
REQ-026 Match when registered cnt_val == compare_val; interrupt_status sets the following cycle and stays set.
REQ-027 Set has priority over interrupt_clear in the same cycle; clear otherwise takes effect the next cycle.
REQ-028 Match is evaluated irrespective of timer_en, so a load equal to compare_val sets the flag.

Reset
REQ-029 On sys_rst_n=0: cnt_val=0, div_cnt=0, halt_ack_status=0, interrupt_status=0, tim_int=0, asynchronously.
REQ-030 Reset mid-prescale discards the partial count; first tick after release follows REQ-017 from div_cnt=0.

Configuration
REQ-031 Macro TIMER_HALT_SUPPORT_EN: defined -> REQ-025 behaviour; undefined -> halt_req ignored, halt_ack_status tied 0, no halt freeze.

Verification
REQ-032 timer_en=1, div_en=0, 10 cycles -> cnt_val=10.
REQ-033 div_en=1, div_val=2, timer_en=1, 16 cycles -> cnt_val=4, one tick every 4th cycle.
REQ-034 Load hi=0xFFFF_FFFF, lo=0xFFFF_FFFE, count 2 ticks -> 0xFFFF_FFFF_FFFF_FFFF, then 0.
REQ-035 compare_val=5, count to 5 -> interrupt_status=1 one cycle later; tim_int=1 only with interrupt_en=1; interrupt_clear on a non-match cycle -> 0.
REQ-036 halt_req=1 at cnt_val=7 with div_val=3 mid-prescale -> halt_ack_status=1 next cycle, cnt_val and div_cnt frozen; release resumes from the frozen div_cnt.
REQ-037 counter_clear with counter_write_sel=2'b01 in the same cycle -> cnt_val=0.
